// File: rtl/core_pkg.sv
// Shared RV32 front-end definitions: datapath width, reset vector default,
// NOP encoding and the fetch sequencer state encoding.
package core_pkg;

    localparam int          XLEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2,
        FS_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next fetch PC selection: trap beats redirect beats sequential PC+4.
// Redirect and trap targets are word-aligned by clearing bits [1:0].
module fetch_next_pc
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc,
    output logic            flush
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    always_comb begin
        pc_plus4 = pc + XLEN'(4);
        flush    = trap_valid | redirect_valid;
        if (trap_valid) begin
            next_pc = trap_vec & ALIGN_MASK;
        end else if (redirect_valid) begin
            next_pc = redirect_pc & ALIGN_MASK;
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding
// imem request at a time and presents {pc, pc+4, instr} downstream.
//
// state | meaning
// BOOT  | single cycle after reset release, no request issued
// REQ   | request to imem at pc (suppressed while stalled)
// WAIT  | request accepted, response pending
// DROP  | response owed for a killed request, data will be discarded
module fetch_pc_gen
    import core_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_stall,
    input  logic            io_redirect_valid,
    input  logic [XLEN-1:0] io_redirect_pc,
    input  logic            io_trap_valid,
    input  logic [XLEN-1:0] io_trap_vec,
    output logic            io_imem_req_valid,
    input  logic            io_imem_req_ready,
    output logic [XLEN-1:0] io_imem_req_addr,
    input  logic            io_imem_resp_valid,
    input  logic [31:0]     io_imem_resp_data,
    output logic            io_out_valid,
    output logic [XLEN-1:0] io_pc_out,
    output logic [XLEN-1:0] io_pc4_out,
    output logic [31:0]     io_instr_out
);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    logic            flush;

    logic            req_valid;
    logic            pc_load;
    logic            resp_take;
    logic            skid_load;

    logic            out_valid;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc4_out;
    logic [31:0]     instr_out;

    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_pc4;
    logic [31:0]     skid_instr;

    fetch_next_pc #(.XLEN(XLEN)) u_next_pc (
        .pc             (pc),
        .redirect_valid (io_redirect_valid),
        .redirect_pc    (io_redirect_pc),
        .trap_valid     (io_trap_valid),
        .trap_vec       (io_trap_vec),
        .pc_plus4       (pc_plus4),
        .next_pc        (next_pc),
        .flush          (flush)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FS_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        pc_load   = 1'b0;
        resp_take = 1'b0;
        skid_load = 1'b0;
        case (state)
            FS_BOOT: begin
                pc_load   = flush;
                state_nxt = FS_REQ;
            end
            FS_REQ: begin
                req_valid = !io_stall;
                pc_load   = flush;
                // an accepted request killed in the same cycle still owes a response
                if (req_valid && io_imem_req_ready) begin
                    state_nxt = flush ? FS_DROP : FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (flush) begin
                    pc_load   = 1'b1;
                    state_nxt = io_imem_resp_valid ? FS_REQ : FS_DROP;
                end else if (io_imem_resp_valid) begin
                    pc_load   = 1'b1;
                    state_nxt = FS_REQ;
                    skid_load = io_stall;
                    resp_take = !io_stall;
                end
            end
            FS_DROP: begin
                pc_load = flush;
                if (io_imem_resp_valid) begin
                    state_nxt = FS_REQ;
                end
            end
            default: state_nxt = FS_BOOT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_VECTOR;
            out_valid  <= 1'b0;
            pc_out     <= RESET_VECTOR;
            pc4_out    <= RESET_VECTOR + XLEN'(4);
            instr_out  <= NOP_INSTR;
            skid_valid <= 1'b0;
            skid_pc    <= RESET_VECTOR;
            skid_pc4   <= RESET_VECTOR + XLEN'(4);
            skid_instr <= NOP_INSTR;
        end else begin
            if (pc_load) begin
                pc <= next_pc;
            end
            if (flush) begin
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
            end else if (resp_take) begin
                out_valid <= 1'b1;
                pc_out    <= pc;
                pc4_out   <= pc_plus4;
                instr_out <= io_imem_resp_data;
            end else if (skid_load) begin
                skid_valid <= 1'b1;
                skid_pc    <= pc;
                skid_pc4   <= pc_plus4;
                skid_instr <= io_imem_resp_data;
            end else if (!io_stall) begin
                // skid drains on the first unstalled edge; otherwise the valid pulse ends
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    pc_out     <= skid_pc;
                    pc4_out    <= skid_pc4;
                    instr_out  <= skid_instr;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign io_imem_req_valid = req_valid;
    assign io_imem_req_addr  = pc;
    assign io_out_valid      = out_valid;
    assign io_pc_out         = pc_out;
    assign io_pc4_out        = pc4_out;
    assign io_instr_out      = instr_out;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: inputs change and outputs are checked
// just after the falling edge, clear of the rising edge.
module tb_fetch_pc_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_stall = 1'b0;
    logic        io_redirect_valid = 1'b0;
    logic [31:0] io_redirect_pc = '0;
    logic        io_trap_valid = 1'b0;
    logic [31:0] io_trap_vec = '0;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready = 1'b0;
    logic [31:0] io_imem_req_addr;
    logic        io_imem_resp_valid = 1'b0;
    logic [31:0] io_imem_resp_data = '0;
    logic        io_out_valid;
    logic [31:0] io_pc_out;
    logic [31:0] io_pc4_out;
    logic [31:0] io_instr_out;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fetch_pc_gen dut (
        .clock              (clock),
        .reset              (reset),
        .io_stall           (io_stall),
        .io_redirect_valid  (io_redirect_valid),
        .io_redirect_pc     (io_redirect_pc),
        .io_trap_valid      (io_trap_valid),
        .io_trap_vec        (io_trap_vec),
        .io_imem_req_valid  (io_imem_req_valid),
        .io_imem_req_ready  (io_imem_req_ready),
        .io_imem_req_addr   (io_imem_req_addr),
        .io_imem_resp_valid (io_imem_resp_valid),
        .io_imem_resp_data  (io_imem_resp_data),
        .io_out_valid       (io_out_valid),
        .io_pc_out          (io_pc_out),
        .io_pc4_out         (io_pc4_out),
        .io_instr_out       (io_instr_out)
    );

    task automatic idle_inputs();
        io_stall = 1'b0;
        io_redirect_valid = 1'b0;
        io_redirect_pc = '0;
        io_trap_valid = 1'b0;
        io_trap_vec = '0;
        io_imem_req_ready = 1'b0;
        io_imem_resp_valid = 1'b0;
        io_imem_resp_data = '0;
    endtask

    // leaves the bench at a falling edge with the DUT in BOOT
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        idle_inputs();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock);
        #1;
        checks++; if (io_imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", io_imem_req_valid); end
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", io_out_valid); end
        checks++; if (io_pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc_out got %h exp 00000000", io_pc_out); end
        checks++; if (io_pc4_out !== 32'h4) begin errors++; $display("FAIL rst_pc4_out got %h exp 00000004", io_pc4_out); end
        checks++; if (io_instr_out !== 32'h13) begin errors++; $display("FAIL rst_instr got %h exp 00000013", io_instr_out); end
    endtask

    task automatic test_sequential();
        logic [31:0] data_tab [3];
        data_tab[0] = 32'h1111_0001;
        data_tab[1] = 32'h2222_0002;
        data_tab[2] = 32'h3333_0003;
        do_reset();
        #1;
        checks++; if (io_imem_req_valid !== 1'b0) begin errors++; $display("FAIL seq_boot_req got %b exp 0", io_imem_req_valid); end
        io_imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            io_imem_resp_valid = 1'b0;
            #1;
            checks++; if (io_imem_req_valid !== 1'b1) begin errors++; $display("FAIL seq_req_valid[%0d] got %b exp 1", i, io_imem_req_valid); end
            checks++; if (io_imem_req_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_req_addr[%0d] got %h exp %h", i, io_imem_req_addr, 32'(4 * i)); end
            checks++; if (io_out_valid !== (i > 0)) begin errors++; $display("FAIL seq_out_valid_req[%0d] got %b exp %b", i, io_out_valid, i > 0); end
            if (i > 0) begin
                checks++; if (io_pc4_out !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc4[%0d] got %h exp %h", i, io_pc4_out, 32'(4 * i)); end
                checks++; if (io_instr_out !== data_tab[i - 1]) begin errors++; $display("FAIL seq_instr[%0d] got %h exp %h", i, io_instr_out, data_tab[i - 1]); end
            end
            cyc();
            io_imem_resp_valid = 1'b1;
            io_imem_resp_data = data_tab[i];
            #1;
            checks++; if (io_imem_req_valid !== 1'b0) begin errors++; $display("FAIL seq_wait_req[%0d] got %b exp 0", i, io_imem_req_valid); end
            checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL seq_out_valid_wait[%0d] got %b exp 0", i, io_out_valid); end
        end
        cyc();
        io_imem_resp_valid = 1'b0;
        io_imem_req_ready = 1'b0;
        #1;
        checks++; if (io_out_valid !== 1'b1) begin errors++; $display("FAIL seq_last_valid got %b exp 1", io_out_valid); end
        checks++; if (io_pc_out !== 32'h8) begin errors++; $display("FAIL seq_last_pc got %h exp 00000008", io_pc_out); end
        checks++; if (io_pc4_out !== 32'hC) begin errors++; $display("FAIL seq_last_pc4 got %h exp 0000000c", io_pc4_out); end
        checks++; if (io_instr_out !== data_tab[2]) begin errors++; $display("FAIL seq_last_instr got %h exp %h", io_instr_out, data_tab[2]); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        io_imem_req_ready = 1'b1;
        cyc();
        cyc();
        io_redirect_valid = 1'b1;
        io_redirect_pc = 32'h103;
        #1;
        checks++; if (io_imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_wait_req got %b exp 0", io_imem_req_valid); end
        cyc();
        io_redirect_valid = 1'b0;
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (io_imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_drop_req got %b exp 0", io_imem_req_valid); end
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL rdw_drop_out_valid got %b exp 0", io_out_valid); end
        cyc();
        io_imem_resp_valid = 1'b0;
        io_imem_req_ready = 1'b0;
        #1;
        checks++; if (io_imem_req_valid !== 1'b1) begin errors++; $display("FAIL rdw_req_valid got %b exp 1", io_imem_req_valid); end
        checks++; if (io_imem_req_addr !== 32'h100) begin errors++; $display("FAIL rdw_req_addr got %h exp 00000100", io_imem_req_addr); end
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL rdw_out_valid got %b exp 0", io_out_valid); end
        checks++; if (io_instr_out !== 32'h13) begin errors++; $display("FAIL rdw_instr got %h exp 00000013", io_instr_out); end
    endtask

    task automatic test_redirect_req_accept();
        do_reset();
        cyc();
        io_imem_req_ready = 1'b1;
        io_redirect_valid = 1'b1;
        io_redirect_pc = 32'h40;
        #1;
        checks++; if (io_imem_req_addr !== 32'h0) begin errors++; $display("FAIL rra_old_addr got %h exp 00000000", io_imem_req_addr); end
        cyc();
        io_redirect_valid = 1'b0;
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data = 32'hBAD0_0001;
        #1;
        checks++; if (io_imem_req_valid !== 1'b0) begin errors++; $display("FAIL rra_drop_req got %b exp 0", io_imem_req_valid); end
        cyc();
        io_imem_resp_valid = 1'b0;
        io_imem_req_ready = 1'b0;
        #1;
        checks++; if (io_imem_req_addr !== 32'h40) begin errors++; $display("FAIL rra_new_addr got %h exp 00000040", io_imem_req_addr); end
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL rra_out_valid got %b exp 0", io_out_valid); end
        checks++; if (io_instr_out !== 32'h13) begin errors++; $display("FAIL rra_instr got %h exp 00000013", io_instr_out); end
    endtask

    task automatic test_trap_priority();
        do_reset();
        cyc();
        io_trap_valid = 1'b1;
        io_trap_vec = 32'h80;
        io_redirect_valid = 1'b1;
        io_redirect_pc = 32'h200;
        #1;
        checks++; if (io_imem_req_addr !== 32'h0) begin errors++; $display("FAIL trap_pre_addr got %h exp 00000000", io_imem_req_addr); end
        cyc();
        io_trap_valid = 1'b0;
        io_redirect_valid = 1'b0;
        #1;
        checks++; if (io_imem_req_valid !== 1'b1) begin errors++; $display("FAIL trap_req_valid got %b exp 1", io_imem_req_valid); end
        checks++; if (io_imem_req_addr !== 32'h80) begin errors++; $display("FAIL trap_req_addr got %h exp 00000080", io_imem_req_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        cyc();
        io_redirect_valid = 1'b1;
        io_redirect_pc = 32'hFFFF_FFFC;
        cyc();
        io_redirect_valid = 1'b0;
        io_imem_req_ready = 1'b1;
        #1;
        checks++; if (io_imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req_addr got %h exp fffffffc", io_imem_req_addr); end
        cyc();
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data = 32'hABCD_0123;
        cyc();
        io_imem_resp_valid = 1'b0;
        io_imem_req_ready = 1'b0;
        #1;
        checks++; if (io_out_valid !== 1'b1) begin errors++; $display("FAIL wrap_out_valid got %b exp 1", io_out_valid); end
        checks++; if (io_pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc_out got %h exp fffffffc", io_pc_out); end
        checks++; if (io_pc4_out !== 32'h0) begin errors++; $display("FAIL wrap_pc4_out got %h exp 00000000", io_pc4_out); end
        checks++; if (io_imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got %h exp 00000000", io_imem_req_addr); end
    endtask

    task automatic test_stall_skid();
        do_reset();
        io_imem_req_ready = 1'b1;
        cyc();
        cyc();
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data = 32'hD000_0000;
        cyc();
        io_imem_resp_valid = 1'b0;
        cyc();
        io_stall = 1'b1;
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data = 32'h5555_AAAA;
        #1;
        checks++; if (io_imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_wait_req got %b exp 0", io_imem_req_valid); end
        for (int i = 0; i < 2; i++) begin
            cyc();
            io_imem_resp_valid = 1'b0;
            #1;
            checks++; if (io_imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid[%0d] got %b exp 0", i, io_imem_req_valid); end
            checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL stall_out_valid[%0d] got %b exp 0", i, io_out_valid); end
            checks++; if (io_instr_out !== 32'hD000_0000) begin errors++; $display("FAIL stall_instr_hold[%0d] got %h exp d0000000", i, io_instr_out); end
            checks++; if (io_pc_out !== 32'h0) begin errors++; $display("FAIL stall_pc_hold[%0d] got %h exp 00000000", i, io_pc_out); end
        end
        cyc();
        io_stall = 1'b0;
        io_imem_req_ready = 1'b0;
        #1;
        checks++; if (io_imem_req_addr !== 32'h8) begin errors++; $display("FAIL stall_release_addr got %h exp 00000008", io_imem_req_addr); end
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %b exp 0", io_out_valid); end
        cyc();
        #1;
        checks++; if (io_out_valid !== 1'b1) begin errors++; $display("FAIL skid_out_valid got %b exp 1", io_out_valid); end
        checks++; if (io_pc_out !== 32'h4) begin errors++; $display("FAIL skid_pc_out got %h exp 00000004", io_pc_out); end
        checks++; if (io_pc4_out !== 32'h8) begin errors++; $display("FAIL skid_pc4_out got %h exp 00000008", io_pc4_out); end
        checks++; if (io_instr_out !== 32'h5555_AAAA) begin errors++; $display("FAIL skid_instr got %h exp 5555aaaa", io_instr_out); end
    endtask

    task automatic test_async_reset();
        do_reset();
        io_imem_req_ready = 1'b1;
        cyc();
        cyc();
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data = 32'h7777_0007;
        cyc();
        io_imem_resp_valid = 1'b0;
        cyc();
        #2;
        reset = 1'b0;
        #1;
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b exp 0", io_out_valid); end
        checks++; if (io_pc_out !== 32'h0) begin errors++; $display("FAIL arst_pc_out got %h exp 00000000", io_pc_out); end
        checks++; if (io_pc4_out !== 32'h4) begin errors++; $display("FAIL arst_pc4_out got %h exp 00000004", io_pc4_out); end
        checks++; if (io_instr_out !== 32'h13) begin errors++; $display("FAIL arst_instr got %h exp 00000013", io_instr_out); end
        checks++; if (io_imem_req_valid !== 1'b0) begin errors++; $display("FAIL arst_req_valid got %b exp 0", io_imem_req_valid); end
        cyc();
        reset = 1'b1;
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data = 32'hBAD0_BAD0;
        cyc();
        io_imem_resp_valid = 1'b0;
        #1;
        checks++; if (io_imem_req_valid !== 1'b1) begin errors++; $display("FAIL arst_first_req got %b exp 1", io_imem_req_valid); end
        checks++; if (io_imem_req_addr !== 32'h0) begin errors++; $display("FAIL arst_first_addr got %h exp 00000000", io_imem_req_addr); end
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL arst_stray_valid got %b exp 0", io_out_valid); end
        checks++; if (io_instr_out !== 32'h13) begin errors++; $display("FAIL arst_stray_instr got %h exp 00000013", io_instr_out); end
        cyc();
        io_imem_resp_valid = 1'b1;
        io_imem_resp_data = 32'h600D_0001;
        cyc();
        io_imem_resp_valid = 1'b0;
        io_imem_req_ready = 1'b0;
        #1;
        checks++; if (io_instr_out !== 32'h600D_0001) begin errors++; $display("FAIL arst_good_instr got %h exp 600d0001", io_instr_out); end
        checks++; if (io_pc4_out !== 32'h4) begin errors++; $display("FAIL arst_good_pc4 got %h exp 00000004", io_pc4_out); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_sequential();
        test_redirect_wait();
        test_redirect_req_accept();
        test_trap_priority();
        test_wrap();
        test_stall_skid();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
